// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from the read side of a dual-clock FIFO
// and forwards it on a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int DSIZE  = 8,
    parameter int ASIZE  = 4,
    parameter int BLEN_W = 5
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              start,
    input  logic [BLEN_W-1:0] blen,
    output logic              busy,
    output logic              done,
    input  logic              rempty,
    output logic              rinc,
    input  logic [DSIZE-1:0]  rdata,
    output logic              m_valid,
    output logic [DSIZE-1:0]  m_data,
    output logic              m_last,
    input  logic              m_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    if (ASIZE < 1 || DSIZE < 1 || BLEN_W < 1) begin : g_bad_params
        $error("fifo_burst_reader: parameters must be positive");
    end

    state_t            state, state_n;
    logic [BLEN_W-1:0] remaining;
    logic [1:0]        cnt;
    logic              rd_ptr, wr_ptr;
    logic [DSIZE-1:0]  mem_data [2];
    logic              mem_last [2];
    logic              pop;

    assign m_valid = cnt != 2'd0;
    assign m_data  = mem_data[rd_ptr];
    assign m_last  = mem_last[rd_ptr];
    assign pop     = m_valid && m_ready;

    // rinc looks only at registered state and rempty so the FIFO never sees m_ready
    always_comb begin
        state_n = state;
        rinc    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (start) state_n = (blen == '0) ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                rinc = !rempty && remaining != '0 && cnt != 2'd2;
                if (rinc && remaining == BLEN_W'(1)) state_n = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && m_last) state_n = DONE;
            end
            default: begin
                done    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state       <= IDLE;
            remaining   <= '0;
            cnt         <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last[0] <= 1'b0;
            mem_last[1] <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) remaining <= blen;
            else if (rinc) remaining <= remaining - BLEN_W'(1);
            if (rinc) begin
                mem_data[wr_ptr] <= rdata;
                mem_last[wr_ptr] <= remaining == BLEN_W'(1);
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, rinc} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scenarios against a behavioural FIFO read port.
module tb_fifo_burst_reader;
    logic       rclk = 1'b0;
    logic       rrst, start, rempty, rinc, busy, done, m_valid, m_last, m_ready;
    logic [4:0] blen;
    logic [7:0] rdata, m_data;

    int errors = 0, checks = 0;
    int rd_idx = 0, wr_idx = 0, pops = 0, hs = 0, done_cnt = 0;
    bit bad_pop = 0;
    logic [7:0] fmem [0:255];
    logic [7:0] cap_data [0:255];
    logic       cap_last [0:255];

    fifo_burst_reader #(.DSIZE(8), .ASIZE(4), .BLEN_W(5)) dut (
        .rclk(rclk), .rrst(rrst), .start(start), .blen(blen), .busy(busy), .done(done),
        .rempty(rempty), .rinc(rinc), .rdata(rdata), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready)
    );

    always #5 rclk = ~rclk;

    assign rempty = rd_idx == wr_idx;
    assign rdata  = fmem[rd_idx];

    always @(posedge rclk) begin
        if (rinc) begin
            rd_idx <= rd_idx + 1;
            pops   <= pops + 1;
            if (rempty) bad_pop <= 1'b1;
        end
        if (m_valid && m_ready) begin
            cap_data[hs] <= m_data;
            cap_last[hs] <= m_last;
            hs           <= hs + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        fmem[wr_idx] = v;
        wr_idx = wr_idx + 1;
    endtask

    task automatic go(input logic [4:0] n);
        start = 1'b1;
        blen  = n;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rrst = 1'b1; start = 1'b0; blen = '0; m_ready = 1'b0;
        #12;
        checks++;
        if ({busy, done, rinc, m_valid, m_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, rinc, m_valid, m_last});
        end
        checks++;
        if (m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", m_data);
        end
        @(negedge rclk);
        rrst = 1'b0;
        tick;
        checks++;
        if ({busy, done, rinc, m_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b want 0000", {busy, done, rinc, m_valid});
        end
    endtask

    task automatic test_basic;
        logic [4:0] exp_f [0:6];
        logic [7:0] exp_d [0:6];
        exp_f = '{5'b10010, 5'b11010, 5'b11010, 5'b11010, 5'b01110, 5'b00001, 5'b00000};
        exp_d = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        m_ready = 1'b1;
        go(5'd4);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({rinc, m_valid, m_valid & m_last, busy, done} !== exp_f[c]) begin
                errors++;
                $display("FAIL basic_flags c%0d: got %b want %b", c, {rinc, m_valid, m_valid & m_last, busy, done}, exp_f[c]);
            end
            if (exp_f[c][3]) begin
                checks++;
                if (m_data !== exp_d[c]) begin
                    errors++;
                    $display("FAIL basic_data c%0d: got %h want %h", c, m_data, exp_d[c]);
                end
            end
            tick;
        end
    endtask

    task automatic test_stall;
        int base, p0, d0;
        bit ok;
        for (int i = 0; i < 3; i++) push(8'h10 + 8'(i));
        base = hs; p0 = pops; d0 = done_cnt;
        m_ready = 1'b0;
        go(5'd3);
        repeat (6) tick;
        checks++;
        if (pops - p0 != 2 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL stall_pops: got pops=%0d rinc=%b want pops=2 rinc=0", pops - p0, rinc);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h10) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h want valid=1 data=10", m_valid, m_data);
        end
        m_ready = 1'b1;
        wait_done(d0, ok);
        checks++;
        if (!ok || hs - base != 3 || pops - p0 != 3) begin
            errors++;
            $display("FAIL stall_done: got ok=%0d words=%0d pops=%0d want ok=1 words=3 pops=3", ok, hs - base, pops - p0);
        end
        checks++;
        if ({cap_data[base], cap_data[base+1], cap_data[base+2]} !== 24'h101112 ||
            {cap_last[base], cap_last[base+1], cap_last[base+2]} !== 3'b001) begin
            errors++;
            $display("FAIL stall_order: got %h %h %h last %b%b%b want 10 11 12 last 001",
                     cap_data[base], cap_data[base+1], cap_data[base+2],
                     cap_last[base], cap_last[base+1], cap_last[base+2]);
        end
    endtask

    task automatic test_empty;
        int base, p0, d0;
        bit ok;
        base = hs; p0 = pops; d0 = done_cnt;
        m_ready = 1'b1;
        go(5'd2);
        repeat (4) tick;
        checks++;
        if (rinc !== 1'b0 || pops != p0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_stall: got rinc=%b pops=%0d busy=%b want rinc=0 pops=0 busy=1", rinc, pops - p0, busy);
        end
        push(8'hA5);
        repeat (4) tick;
        push(8'h5A);
        wait_done(d0, ok);
        checks++;
        if (!ok || hs - base != 2 || cap_data[base] !== 8'hA5 || cap_data[base+1] !== 8'h5A ||
            cap_last[base] !== 1'b0 || cap_last[base+1] !== 1'b1) begin
            errors++;
            $display("FAIL empty_words: got ok=%0d n=%0d %h/%b %h/%b want 1 2 a5/0 5a/1", ok, hs - base,
                     cap_data[base], cap_last[base], cap_data[base+1], cap_last[base+1]);
        end
        checks++;
        if (bad_pop !== 1'b0) begin
            errors++;
            $display("FAIL pop_when_empty: got %b want 0", bad_pop);
        end
    endtask

    task automatic test_zero;
        int p0;
        p0 = pops;
        go(5'd0);
        checks++;
        if ({done, busy, m_valid, rinc} !== 4'b1000) begin
            errors++;
            $display("FAIL zero_done: got %b want 1000", {done, busy, m_valid, rinc});
        end
        tick;
        checks++;
        if ({done, busy, m_valid} !== 3'b000 || pops != p0) begin
            errors++;
            $display("FAIL zero_after: got %b pops=%0d want 000 pops=0", {done, busy, m_valid}, pops - p0);
        end
    endtask

    task automatic test_reset_mid;
        int base, p0, d0;
        bit ok;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        base = hs; p0 = pops;
        m_ready = 1'b1;
        go(5'd5);
        for (int i = 0; i < 20 && hs - base < 2; i++) tick;
        checks++;
        if (hs - base != 2 || pops - p0 != 3) begin
            errors++;
            $display("FAIL rmid_progress: got words=%0d pops=%0d want 2 3", hs - base, pops - p0);
        end
        #2 rrst = 1'b1;
        #1;
        checks++;
        if ({busy, done, rinc, m_valid, m_last} !== 5'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL rmid_async: got %b data=%h want 00000 data=00", {busy, done, rinc, m_valid, m_last}, m_data);
        end
        @(negedge rclk);
        rrst = 1'b0;
        tick;
        base = hs; d0 = done_cnt;
        go(5'd1);
        wait_done(d0, ok);
        checks++;
        if (!ok || hs - base != 1 || cap_data[base] !== 8'h23 || cap_last[base] !== 1'b1) begin
            errors++;
            $display("FAIL rmid_restart: got ok=%0d n=%0d %h/%b want 1 1 23/1", ok, hs - base, cap_data[base], cap_last[base]);
        end
    endtask

    task automatic test_ignore;
        int base, p0;
        bit ok;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        base = hs; p0 = pops;
        m_ready = 1'b1;
        go(5'd3);
        start = 1'b1; blen = 5'd7;
        tick;
        blen = 5'd1;
        tick;
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            tick;
        end
        start = 1'b1; blen = 5'd1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        checks++;
        if (!ok || pops - p0 != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_count: got ok=%0d pops=%0d busy=%b want 1 3 0", ok, pops - p0, busy);
        end
        checks++;
        if (hs - base != 3 || {cap_data[base], cap_data[base+1], cap_data[base+2]} !== 24'h404142 ||
            {cap_last[base], cap_last[base+1], cap_last[base+2]} !== 3'b001) begin
            errors++;
            $display("FAIL ignore_words: got n=%0d %h %h %h want 3 40 41 42", hs - base,
                     cap_data[base], cap_data[base+1], cap_data[base+2]);
        end
    endtask

    task automatic test_max;
        int base, p0, d0, bad;
        bit ok;
        logic [7:0] want;
        for (int i = 0; i < 30; i++) push(8'(i));
        base = hs; p0 = pops; d0 = done_cnt; bad = 0;
        m_ready = 1'b1;
        go(5'd31);
        wait_done(d0, ok);
        checks++;
        if (!ok || hs - base != 31 || pops - p0 != 31) begin
            errors++;
            $display("FAIL max_count: got ok=%0d words=%0d pops=%0d want 1 31 31", ok, hs - base, pops - p0);
        end
        for (int k = 0; k < 31; k++) begin
            want = (k == 0) ? 8'h43 : 8'(k - 1);
            if (cap_data[base+k] !== want || cap_last[base+k] !== (k == 30)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL max_order: got %0d bad words want 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_empty;
        test_zero;
        test_reset_mid;
        test_ignore;
        test_max;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
